// File: rtl/io_bus_router_if.sv
// io_bus_interface: single-master strobe bus (read data returns one cycle after read_en).
interface io_bus_interface;
   logic        read_en;
   logic        write_en;
   logic [31:0] adress;
   logic [31:0] write_data;
   logic [31:0] read_data;

   modport master(output read_en, write_en, adress, write_data, input read_data);
   modport slave(input read_en, write_en, adress, write_data, output read_data);
endinterface

// File: rtl/io_bus_router.sv
// io_bus_router: decodes the core io_bus into peripheral ports by 64-byte window and traps unmapped accesses.
// Optional IO_ROUTER_STATS_EN adds per-port 16-bit saturating access counters at local offsets 'h20+4*i.
module io_bus_router #(
   parameter int                           NUM_PERIPHERALS = 5,
   parameter logic [NUM_PERIPHERALS*8-1:0] WINDOW_MAP      = {8'd9, 8'd6, 8'd2, 8'd3, 8'd1},
   parameter logic [13:0]                  STATUS_ADDR     = 14'h38,
   parameter logic [13:0]                  ERR_ADDR_ADDR   = 14'h3c
) (
   input  logic                   clk,
   input  logic                   reset,
   io_bus_interface.slave         host_bus,
   io_bus_interface.master        periph_bus[NUM_PERIPHERALS],
   output logic                   local_sel,
   input  logic [31:0]            local_rdata,
   output logic                   err_irq
);

   typedef enum logic [2:0] {
      RS_NONE, RS_PORT, RS_LOCAL, RS_STATUS, RS_ERRADDR, RS_STATS
   } rd_src_t;

   rd_src_t                              rd_src, rd_src_nxt;
   logic [3:0]                           rd_idx, hit_idx;
   logic [7:0]                           win;
   logic [NUM_PERIPHERALS-1:0]           hit;
   logic [NUM_PERIPHERALS-1:0][31:0]     port_rdata;
   logic                                 access, unmapped, status_wr;
   logic                                 err_sticky, err_overflow, err_write;
   logic [31:0]                          err_addr;

   assign win       = host_bus.adress[13:6];
   assign access    = host_bus.read_en | host_bus.write_en;
   assign local_sel = (win == 8'd0);
   assign unmapped  = access && !(|hit) && !local_sel;
   assign status_wr = host_bus.write_en && host_bus.adress[13:0] == STATUS_ADDR;
   assign err_irq   = err_sticky;

   for (genvar i = 0; i < NUM_PERIPHERALS; i++) begin : g_port
      assign hit[i]                   = (win == WINDOW_MAP[i*8 +: 8]);
      assign periph_bus[i].read_en    = host_bus.read_en & hit[i];
      assign periph_bus[i].write_en   = host_bus.write_en & hit[i];
      assign periph_bus[i].adress     = host_bus.adress;
      assign periph_bus[i].write_data = host_bus.write_data;
      assign port_rdata[i]            = periph_bus[i].read_data;

      if (WINDOW_MAP[i*8 +: 8] == 8'd0) begin : g_bad_zero
         $error("io_bus_router: WINDOW_MAP entry %0d maps to the local window", i);
      end
      for (genvar j = i + 1; j < NUM_PERIPHERALS; j++) begin : g_dup
         if (WINDOW_MAP[i*8 +: 8] == WINDOW_MAP[j*8 +: 8]) begin : g_bad_dup
            $error("io_bus_router: WINDOW_MAP entries %0d and %0d collide", i, j);
         end
      end
   end

   always_comb begin
      hit_idx = '0;
      for (int i = 0; i < NUM_PERIPHERALS; i++)
         if (hit[i]) hit_idx = 4'(i);
   end

   // Router-owned registers shadow local_rdata inside window 0.
   always_comb begin
      rd_src_nxt = RS_NONE;
      if (|hit)
         rd_src_nxt = RS_PORT;
      else if (local_sel) begin
         if (host_bus.adress[13:0] == STATUS_ADDR)
            rd_src_nxt = RS_STATUS;
         else if (host_bus.adress[13:0] == ERR_ADDR_ADDR)
            rd_src_nxt = RS_ERRADDR;
`ifdef IO_ROUTER_STATS_EN
         else if (host_bus.adress[5] && host_bus.adress[4:2] < 3'd6)
            rd_src_nxt = RS_STATS;
`endif
         else
            rd_src_nxt = RS_LOCAL;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_src <= RS_NONE;
         rd_idx <= '0;
      end else if (host_bus.read_en) begin
         rd_src <= rd_src_nxt;
         rd_idx <= (rd_src_nxt == RS_PORT) ? hit_idx : {1'b0, host_bus.adress[4:2]};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         err_sticky   <= 1'b0;
         err_overflow <= 1'b0;
         err_write    <= 1'b0;
         err_addr     <= '0;
      end else if (unmapped) begin
         err_sticky <= 1'b1;
         if (err_sticky)
            err_overflow <= 1'b1;
         else begin
            err_addr  <= host_bus.adress;
            err_write <= host_bus.write_en;
         end
      end else if (status_wr && host_bus.write_data[0]) begin
         err_sticky   <= 1'b0;
         err_overflow <= 1'b0;
         err_write    <= 1'b0;
      end
   end

`ifdef IO_ROUTER_STATS_EN
   logic [NUM_PERIPHERALS-1:0][15:0] acc_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         acc_cnt <= '0;
      else if (status_wr && host_bus.write_data[1])
         acc_cnt <= '0;
      else
         for (int i = 0; i < NUM_PERIPHERALS; i++)
            if (access && hit[i] && acc_cnt[i] != 16'hffff)
               acc_cnt[i] <= acc_cnt[i] + 16'd1;
   end
`endif

   always_comb begin
      host_bus.read_data = 32'h0;
      case (rd_src)
         RS_PORT:
            for (int i = 0; i < NUM_PERIPHERALS; i++)
               if (rd_idx == 4'(i)) host_bus.read_data = port_rdata[i];
         RS_LOCAL:   host_bus.read_data = local_rdata;
         RS_STATUS:  host_bus.read_data = {28'b0, err_overflow, err_write, 1'b0, err_sticky};
         RS_ERRADDR: host_bus.read_data = err_addr;
`ifdef IO_ROUTER_STATS_EN
         RS_STATS:
            for (int i = 0; i < NUM_PERIPHERALS && i < 6; i++)
               if (rd_idx == 4'(i)) host_bus.read_data = {16'b0, acc_cnt[i]};
`endif
         default: host_bus.read_data = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_io_bus_router.sv
// Directed self-checking bench for io_bus_router with registered peripheral models on every port.
module tb_io_bus_router;
   localparam int N = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] local_rdata;
   logic        local_sel;
   logic        err_irq;
   int          tests = 0;
   int          fails = 0;

   io_bus_interface host_bus();
   io_bus_interface periph_bus[N]();

   logic [N-1:0]       p_rd, p_wr;
   logic [N-1:0][31:0] p_addr, p_wdata;

   always #5 clk = ~clk;

   io_bus_router dut (
      .clk        (clk),
      .reset      (reset),
      .host_bus   (host_bus),
      .periph_bus (periph_bus),
      .local_sel  (local_sel),
      .local_rdata(local_rdata),
      .err_irq    (err_irq)
   );

   // Peripheral g answers A5A5_0000 + g + 1 one cycle after its read_en.
   for (genvar g = 0; g < N; g++) begin : g_per
      logic [31:0] rdata_q;
      always @(posedge clk) rdata_q <= periph_bus[g].read_en ? 32'hA5A5_0000 + 32'(g + 1) : 32'h0;
      assign periph_bus[g].read_data = rdata_q;
      assign p_rd[g]    = periph_bus[g].read_en;
      assign p_wr[g]    = periph_bus[g].write_en;
      assign p_addr[g]  = periph_bus[g].adress;
      assign p_wdata[g] = periph_bus[g].write_data;
   end

   task automatic host_read(input logic [31:0] addr, output logic [31:0] data);
      @(negedge clk);
      host_bus.read_en = 1'b1;
      host_bus.adress  = addr;
      @(negedge clk);
      data = host_bus.read_data;
      host_bus.read_en = 1'b0;
   endtask

   task automatic host_write(input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      host_bus.write_en   = 1'b1;
      host_bus.adress     = addr;
      host_bus.write_data = wdata;
      @(negedge clk);
      host_bus.write_en = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      tests++; if (host_bus.read_data !== 32'h0) begin fails++; $display("FAIL reset_rdata got %h want 0", host_bus.read_data); end
      tests++; if (err_irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", err_irq); end
      tests++; if ((p_rd | p_wr) !== '0) begin fails++; $display("FAIL reset_strobes rd %b wr %b want 0", p_rd, p_wr); end
      reset = 1'b0;
   endtask

   task automatic test_uart_read();
      @(negedge clk);
      host_bus.read_en = 1'b1;
      host_bus.adress  = 32'h40;
      #1;
      tests++; if (p_rd !== 5'b00001) begin fails++; $display("FAIL uart_rd_strobe got %b want 00001", p_rd); end
      tests++; if (p_wr !== 5'b00000) begin fails++; $display("FAIL uart_wr_strobe got %b want 00000", p_wr); end
      @(negedge clk);
      tests++; if (host_bus.read_data !== 32'hA5A5_0001) begin fails++; $display("FAIL uart_rdata got %h want a5a50001", host_bus.read_data); end
      host_bus.read_en = 1'b0;
   endtask

   task automatic test_timer_write();
      @(negedge clk);
      host_bus.write_en   = 1'b1;
      host_bus.adress     = 32'h244;
      host_bus.write_data = 32'd5;
      #1;
      tests++; if (p_wr !== 5'b10000) begin fails++; $display("FAIL timer_wr_strobe got %b want 10000", p_wr); end
      tests++; if (p_rd !== 5'b00000) begin fails++; $display("FAIL timer_rd_strobe got %b want 00000", p_rd); end
      tests++; if (p_addr[4] !== 32'h244) begin fails++; $display("FAIL timer_addr got %h want 244", p_addr[4]); end
      tests++; if (p_wdata[4] !== 32'd5) begin fails++; $display("FAIL timer_wdata got %h want 5", p_wdata[4]); end
      @(negedge clk);
      host_bus.write_en = 1'b0;
      #1;
      tests++; if (err_irq !== 1'b0) begin fails++; $display("FAIL timer_irq got %b want 0", err_irq); end
   endtask

   task automatic test_unmapped();
      logic [31:0] d;
      @(negedge clk);
      host_bus.write_en = 1'b1;
      host_bus.adress   = 32'h400;
      #1;
      tests++; if ((p_rd | p_wr) !== '0) begin fails++; $display("FAIL unmapped_strobes rd %b wr %b want 0", p_rd, p_wr); end
      @(negedge clk);
      host_bus.write_en = 1'b0;
      tests++; if (err_irq !== 1'b1) begin fails++; $display("FAIL unmapped_irq got %b want 1", err_irq); end
      host_read(32'h3c, d);
      tests++; if (d !== 32'h400) begin fails++; $display("FAIL erraddr_first got %h want 400", d); end
      host_read(32'h38, d);
      tests++; if (d !== 32'h5) begin fails++; $display("FAIL status_first got %h want 5", d); end
   endtask

   task automatic test_overflow_clear();
      logic [31:0] d;
      host_read(32'h500, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_rdata got %h want 0", d); end
      host_read(32'h3c, d);
      tests++; if (d !== 32'h400) begin fails++; $display("FAIL erraddr_kept got %h want 400", d); end
      host_read(32'h38, d);
      tests++; if (d !== 32'hD) begin fails++; $display("FAIL status_overflow got %h want d", d); end
      host_write(32'h38, 32'h1);
      #1;
      tests++; if (err_irq !== 1'b0) begin fails++; $display("FAIL clear_irq got %b want 0", err_irq); end
      host_read(32'h38, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL status_cleared got %h want 0", d); end
      host_read(32'h3c, d);
      tests++; if (d !== 32'h400) begin fails++; $display("FAIL erraddr_after_clear got %h want 400", d); end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      host_bus.read_en = 1'b1;
      host_bus.adress  = 32'h80;
      @(negedge clk);
      tests++; if (host_bus.read_data !== 32'hA5A5_0003) begin fails++; $display("FAIL b2b_ps2 got %h want a5a50003", host_bus.read_data); end
      host_bus.adress = 32'hc0;
      @(negedge clk);
      tests++; if (host_bus.read_data !== 32'hA5A5_0002) begin fails++; $display("FAIL b2b_spi got %h want a5a50002", host_bus.read_data); end
      host_bus.read_en = 1'b0;
   endtask

   task automatic test_local();
      logic [31:0] d;
      @(negedge clk);
      host_bus.read_en = 1'b1;
      host_bus.adress  = 32'h10;
      #1;
      tests++; if (local_sel !== 1'b1) begin fails++; $display("FAIL local_sel got %b want 1", local_sel); end
      @(negedge clk);
      tests++; if (host_bus.read_data !== 32'h1234_5678) begin fails++; $display("FAIL local_rdata got %h want 12345678", host_bus.read_data); end
      host_bus.read_en = 1'b0;
      host_bus.adress  = 32'h40;
      #1;
      tests++; if (local_sel !== 1'b0) begin fails++; $display("FAIL local_sel_off got %b want 0", local_sel); end
`ifndef IO_ROUTER_STATS_EN
      host_read(32'h20, d);
      tests++; if (d !== 32'h1234_5678) begin fails++; $display("FAIL local_20 got %h want 12345678", d); end
`else
      d = 32'h0;
`endif
   endtask

   task automatic test_reset_mid_read();
      logic [31:0] d;
      host_write(32'h400, 32'h0);
      @(negedge clk);
      host_bus.read_en = 1'b1;
      host_bus.adress  = 32'h180;
      @(posedge clk);
      #1;
      reset            = 1'b1;
      host_bus.read_en = 1'b0;
      #1;
      tests++; if (host_bus.read_data !== 32'h0) begin fails++; $display("FAIL midread_rdata got %h want 0", host_bus.read_data); end
      tests++; if (err_irq !== 1'b0) begin fails++; $display("FAIL midread_irq got %b want 0", err_irq); end
      @(negedge clk);
      reset = 1'b0;
      host_read(32'h38, d);
      tests++; if (d !== 32'h0) begin fails++; $display("FAIL midread_status got %h want 0", d); end
   endtask

`ifdef IO_ROUTER_STATS_EN
   task automatic test_stats();
      logic [31:0] d;
      repeat (3) host_read(32'h40, d);
      host_read(32'h20, d);
      tests++; if (d !== 32'd3) begin fails++; $display("FAIL stats_uart got %h want 3", d); end
      host_read(32'h24, d);
      tests++; if (d !== 32'd0) begin fails++; $display("FAIL stats_spi got %h want 0", d); end
      host_write(32'h38, 32'h2);
      host_read(32'h20, d);
      tests++; if (d !== 32'd0) begin fails++; $display("FAIL stats_clear got %h want 0", d); end
   endtask
`endif

   initial begin
      reset               = 1'b1;
      local_rdata         = 32'h1234_5678;
      host_bus.read_en    = 1'b0;
      host_bus.write_en   = 1'b0;
      host_bus.adress     = 32'h0;
      host_bus.write_data = 32'h0;
      test_reset();
      test_uart_read();
      test_timer_write();
      test_unmapped();
      test_overflow_clear();
      test_back_to_back();
      test_local();
      test_reset_mid_read();
`ifdef IO_ROUTER_STATS_EN
      test_stats();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
